// File: rtl/mii_rx_frame.sv
// MII receive front end: nibble stream to framed byte stream with preamble/SFD stripping,
// CRC-32 residue check, length check and per-frame status reported alongside the last byte.
module mii_rx_frame #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518
) (
  input  logic        eth_rx_clk,
  input  logic        rst,
  input  logic        eth_rxdv,
  input  logic [3:0]  eth_rx_data,
  input  logic        eth_rx_er,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sop,
  output logic        rx_eop,
  output logic [3:0]  rx_err,
  output logic [10:0] rx_len
);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

  localparam logic [10:0] MIN_L   = 11'(MIN_FRAME);
  localparam logic [10:0] MAX_L   = 11'(MAX_FRAME);
  localparam logic [31:0] RESIDUE = 32'hC704DD7B;

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [3:0]  lo_q, lo_d;
  logic        half_q, half_d;
  logic [7:0]  hold_q, hold_d;
  logic        have_q, have_d;
  logic        first_q, first_d;
  logic [10:0] len_q, len_d;
  logic        er_q, er_d;
  logic [7:0]  data_q, data_d;
  logic        vld_q, vld_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;
  logic [3:0]  err_q, err_d;
  logic [10:0] olen_q, olen_d;

  // Reflected CRC-32 advanced by one nibble, LSB first.
  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  function automatic logic [10:0] len_inc(input logic [10:0] l);
    return (l == 11'h7FF) ? l : l + 11'd1;
  endfunction

  function automatic logic len_bad(input logic [10:0] l);
    return (l < MIN_L) || (l > MAX_L);
  endfunction

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    lo_d    = lo_q;
    half_d  = half_q;
    hold_d  = hold_q;
    have_d  = have_q;
    first_d = first_q;
    len_d   = len_q;
    er_d    = er_q;
    data_d  = data_q;
    vld_d   = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    err_d   = err_q;
    olen_d  = olen_q;

    if ((state_q == S_PRE || state_q == S_DATA) && eth_rx_er) er_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (eth_rxdv) begin
          if (eth_rx_data == 4'h5) begin
            state_d = S_PRE;
            crc_d   = '1;
            len_d   = '0;
            er_d    = 1'b0;
            half_d  = 1'b0;
            have_d  = 1'b0;
            first_d = 1'b1;
          end else begin
            state_d = S_DROP;
          end
        end
      end
      S_PRE: begin
        if (!eth_rxdv)                 state_d = S_IDLE;
        else if (eth_rx_data == 4'hD)  state_d = S_DATA;
        else if (eth_rx_data != 4'h5)  state_d = S_DROP;
      end
      S_DATA: begin
        if (eth_rxdv) begin
          crc_d = crc_nib(crc_q, eth_rx_data);
          if (!half_q) begin
            lo_d   = eth_rx_data;
            half_d = 1'b1;
          end else begin
            half_d = 1'b0;
            hold_d = {eth_rx_data, lo_q};
            have_d = 1'b1;
            len_d  = len_inc(len_q);
            // The previous byte is released only once its successor exists, so eop can tag it.
            if (have_q) begin
              vld_d   = 1'b1;
              data_d  = hold_q;
              sop_d   = first_q;
              first_d = 1'b0;
            end
          end
        end else begin
          state_d = S_IDLE;
          if (have_q) begin
            vld_d   = 1'b1;
            data_d  = hold_q;
            sop_d   = first_q;
            eop_d   = 1'b1;
            first_d = 1'b0;
            err_d   = {len_bad(len_q), er_q | eth_rx_er, half_q,
                       bitrev32(crc_q) != RESIDUE};
            olen_d  = len_q;
          end
          have_d = 1'b0;
          half_d = 1'b0;
        end
      end
      S_DROP: begin
        if (!eth_rxdv) state_d = S_IDLE;
      end
      default: state_d = S_DROP;
    endcase
  end

  always_ff @(posedge eth_rx_clk or posedge rst) begin
    if (rst) begin
      state_q <= S_DROP;
      crc_q   <= '1;
      lo_q    <= '0;
      half_q  <= 1'b0;
      hold_q  <= '0;
      have_q  <= 1'b0;
      first_q <= 1'b0;
      len_q   <= '0;
      er_q    <= 1'b0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= '0;
      olen_q  <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      lo_q    <= lo_d;
      half_q  <= half_d;
      hold_q  <= hold_d;
      have_q  <= have_d;
      first_q <= first_d;
      len_q   <= len_d;
      er_q    <= er_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      err_q   <= err_d;
      olen_q  <= olen_d;
    end
  end

  assign rx_data  = data_q;
  assign rx_valid = vld_q;
  assign rx_sop   = sop_q;
  assign rx_eop   = eop_q;
  assign rx_err   = err_q;
  assign rx_len   = olen_q;

endmodule
